// File: rtl/uart_boot_loader.sv
// -----------------------------------------------------------------------------
// uart_boot_loader
//
// Receives a program image over a UART line (8N1, LSB first) and writes it,
// one 32-bit word at a time, into an instruction memory port. The stream is a
// 4-byte little-endian length header N (in words) followed by N words, each
// sent as four little-endian bytes. When the final word is written, the
// pipeline reset is released. A zero length, a length above MAX_WORDS or a
// framing error parks the block in a sticky error state until rst_n.
//
// Parameters
//   CLKS_PER_BIT  clk cycles per UART bit (>= 4)
//   MAX_WORDS     largest accepted program length in 32-bit words
//
// Ports
//   clk         in   single clock, rising edge
//   rst_n       in   asynchronous active-low reset
//   rx          in   UART serial line, asynchronous to clk, idle high
//   we          out  [3:0] byte write enables, 4'b1111 for one cycle per word
//   addr        out  [31:0] word-aligned byte address of the write
//   di          out  [31:0] word being written
//   core_rst_n  out  pipeline reset, released once the load completes
//   busy        out  high while a load is in progress
//   err         out  sticky error flag
// -----------------------------------------------------------------------------
module uart_boot_loader #(
  parameter int CLKS_PER_BIT = 868,
  parameter int MAX_WORDS    = 4096
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        rx,
  output logic [3:0]  we,
  output logic [31:0] addr,
  output logic [31:0] di,
  output logic        core_rst_n,
  output logic        busy,
  output logic        err
);

  // Bit-timing counter only ever holds values up to CLKS_PER_BIT-1.
  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  // Word counter must be able to hold N == MAX_WORDS itself.
  localparam int WC_W  = $clog2(MAX_WORDS + 1);

  localparam logic [CNT_W-1:0] HALF_BIT = CNT_W'(CLKS_PER_BIT / 2);
  localparam logic [CNT_W-1:0] FULL_M1  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [31:0]      MAX_LEN  = 32'(MAX_WORDS);

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
  typedef enum logic [1:0] {L_LEN, L_DATA, L_DONE, L_ERR}        ld_state_t;

  // ---------------------------------------------------------------------------
  // Input synchronizer plus one delayed copy for falling-edge detection.
  // These reset to 1 (line idle) so release from reset never looks like a
  // start bit.
  // ---------------------------------------------------------------------------
  logic r_rx_meta;
  logic r_rx_sync;
  logic r_rx_prev;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge value of its inputs, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rx_meta <= 1'b1;
      r_rx_sync <= 1'b1;
      r_rx_prev <= 1'b1;
    end else begin
      r_rx_meta <= rx;
      r_rx_sync <= r_rx_meta;
      r_rx_prev <= r_rx_sync;
    end
  end

  // ---------------------------------------------------------------------------
  // Receiver FSM
  // ---------------------------------------------------------------------------
  rx_state_t        r_rx_state;
  logic [CNT_W-1:0] r_bit_cnt;
  logic [2:0]       r_bit_idx;
  logic [7:0]       r_shift;
  logic             r_byte_valid;
  logic             r_frame_err;

  rx_state_t        w_rx_state_nx;
  logic [CNT_W-1:0] w_bit_cnt_nx;
  logic [2:0]       w_bit_idx_nx;
  logic [7:0]       w_shift_nx;
  logic             w_byte_valid_nx;
  logic             w_frame_err_nx;
  logic             w_start_ok;
  logic             w_sample;

  // The counter runs down to zero; the cycle it reads zero is the sample point.
  assign w_sample = (r_bit_cnt == '0);

  // NOTE: every output of a combinational block gets a default first, so no
  // path through the case statement can leave a value unassigned (no latch).
  always_comb begin
    w_rx_state_nx   = r_rx_state;
    w_bit_cnt_nx    = r_bit_cnt;
    w_bit_idx_nx    = r_bit_idx;
    w_shift_nx      = r_shift;
    w_byte_valid_nx = 1'b0;
    w_frame_err_nx  = 1'b0;
    w_start_ok      = 1'b0;

    case (r_rx_state)
      RX_IDLE: begin
        if (r_rx_prev && !r_rx_sync) begin
          w_rx_state_nx = RX_START;
          w_bit_cnt_nx  = HALF_BIT;
        end
      end

      RX_START: begin
        if (w_sample) begin
          if (!r_rx_sync) begin
            w_rx_state_nx = RX_DATA;
            w_bit_cnt_nx  = FULL_M1;
            w_bit_idx_nx  = 3'd0;
            w_start_ok    = 1'b1;
          end else begin
            // Line back high at mid-bit: a glitch, not a start bit.
            w_rx_state_nx = RX_IDLE;
          end
        end else begin
          w_bit_cnt_nx = r_bit_cnt - CNT_W'(1);
        end
      end

      RX_DATA: begin
        if (w_sample) begin
          w_shift_nx   = {r_rx_sync, r_shift[7:1]};
          w_bit_cnt_nx = FULL_M1;
          if (r_bit_idx == 3'd7) begin
            w_rx_state_nx = RX_STOP;
          end else begin
            w_bit_idx_nx = r_bit_idx + 3'd1;
          end
        end else begin
          w_bit_cnt_nx = r_bit_cnt - CNT_W'(1);
        end
      end

      RX_STOP: begin
        if (w_sample) begin
          if (r_rx_sync) begin
            w_byte_valid_nx = 1'b1;
          end else begin
            w_frame_err_nx = 1'b1;
          end
          w_rx_state_nx = RX_IDLE;
        end else begin
          w_bit_cnt_nx = r_bit_cnt - CNT_W'(1);
        end
      end

      default: w_rx_state_nx = RX_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rx_state   <= RX_IDLE;
      r_bit_cnt    <= '0;
      r_bit_idx    <= '0;
      r_shift      <= '0;
      r_byte_valid <= 1'b0;
      r_frame_err  <= 1'b0;
    end else begin
      r_rx_state   <= w_rx_state_nx;
      r_bit_cnt    <= w_bit_cnt_nx;
      r_bit_idx    <= w_bit_idx_nx;
      r_shift      <= w_shift_nx;
      r_byte_valid <= w_byte_valid_nx;
      r_frame_err  <= w_frame_err_nx;
    end
  end

  // ---------------------------------------------------------------------------
  // Loader FSM
  // ---------------------------------------------------------------------------
  ld_state_t       r_ld_state;
  logic [1:0]      r_byte_idx;
  logic [31:0]     r_word;
  logic [WC_W-1:0] r_len;
  logic [WC_W-1:0] r_word_cnt;
  logic [3:0]      r_we;
  logic [31:0]     r_addr;
  logic [31:0]     r_di;
  logic            r_busy;

  ld_state_t       w_ld_state_nx;
  logic [1:0]      w_byte_idx_nx;
  logic [31:0]     w_word_nx;
  logic [WC_W-1:0] w_len_nx;
  logic [WC_W-1:0] w_word_cnt_nx;
  logic [3:0]      w_we_nx;
  logic [31:0]     w_addr_nx;
  logic [31:0]     w_di_nx;
  logic            w_busy_nx;
  logic [31:0]     w_full_word;

  // Bytes shift in from the top, so after four bytes byte 0 sits in [7:0].
  // On the fourth byte this is the complete little-endian word.
  assign w_full_word = {r_shift, r_word[31:8]};

  always_comb begin
    w_ld_state_nx = r_ld_state;
    w_byte_idx_nx = r_byte_idx;
    w_word_nx     = r_word;
    w_len_nx      = r_len;
    w_word_cnt_nx = r_word_cnt;
    w_we_nx       = 4'b0000;
    w_addr_nx     = r_addr;
    w_di_nx       = r_di;
    w_busy_nx     = r_busy;

    case (r_ld_state)
      L_LEN: begin
        if (w_start_ok) begin
          w_busy_nx = 1'b1;
        end
        if (r_frame_err) begin
          w_ld_state_nx = L_ERR;
          w_busy_nx     = 1'b0;
        end else if (r_byte_valid) begin
          w_word_nx     = w_full_word;
          w_byte_idx_nx = r_byte_idx + 2'd1;
          if (r_byte_idx == 2'd3) begin
            if ((w_full_word == 32'd0) || (w_full_word > MAX_LEN)) begin
              w_ld_state_nx = L_ERR;
              w_busy_nx     = 1'b0;
            end else begin
              w_len_nx      = w_full_word[WC_W-1:0];
              w_word_cnt_nx = '0;
              w_ld_state_nx = L_DATA;
            end
          end
        end
      end

      L_DATA: begin
        // r_we is set in the write cycle and r_word_cnt has already advanced,
        // so finishing here releases core_rst_n in the cycle after the pulse.
        if ((r_we != 4'b0000) && (r_word_cnt == r_len)) begin
          w_ld_state_nx = L_DONE;
          w_busy_nx     = 1'b0;
        end else if (r_frame_err) begin
          w_ld_state_nx = L_ERR;
          w_busy_nx     = 1'b0;
        end else if (r_byte_valid) begin
          w_word_nx     = w_full_word;
          w_byte_idx_nx = r_byte_idx + 2'd1;
          if (r_byte_idx == 2'd3) begin
            w_we_nx       = 4'b1111;
            w_addr_nx     = 32'({r_word_cnt, 2'b00});
            w_di_nx       = w_full_word;
            w_word_cnt_nx = r_word_cnt + WC_W'(1);
          end
        end
      end

      // Both terminal: bytes keep arriving from the receiver but change nothing.
      L_DONE, L_ERR: begin
        w_busy_nx = 1'b0;
      end

      default: w_ld_state_nx = L_ERR;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ld_state <= L_LEN;
      r_byte_idx <= '0;
      r_word     <= '0;
      r_len      <= '0;
      r_word_cnt <= '0;
      r_we       <= 4'b0000;
      r_addr     <= '0;
      r_di       <= '0;
      r_busy     <= 1'b0;
    end else begin
      r_ld_state <= w_ld_state_nx;
      r_byte_idx <= w_byte_idx_nx;
      r_word     <= w_word_nx;
      r_len      <= w_len_nx;
      r_word_cnt <= w_word_cnt_nx;
      r_we       <= w_we_nx;
      r_addr     <= w_addr_nx;
      r_di       <= w_di_nx;
      r_busy     <= w_busy_nx;
    end
  end

  assign we         = r_we;
  assign addr       = r_addr;
  assign di         = r_di;
  assign busy       = r_busy;
  assign core_rst_n = (r_ld_state == L_DONE);
  assign err        = (r_ld_state == L_ERR);

endmodule

// File: doc/uart_boot_loader.md
UART_BOOT_LOADER -- requirements
Module: uart_boot_loader

Interface
REQ-001 Parameter CLKS_PER_BIT, default 868, clk cycles per UART bit (100 MHz / 115200); SHALL be >= 4.
REQ-002 Parameter MAX_WORDS, default 4096, largest accepted program length in 32-bit words.
REQ-003 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset for the whole block.
REQ-005 rx  input  1  UART serial line, asynchronous to clk, idle high, 8N1, LSB first.
REQ-006 we  output  4  byte write enables to the IMEM port; 4'b1111 for one cycle per stored word.
REQ-007 addr  output  32  byte address of the word being written; always word-aligned.
REQ-008 di  output  32  word being written, little-endian assembled.
REQ-009 core_rst_n  output  1  active-low reset to the pipeline; low until the load completes.
REQ-010 busy  output  1  high while a load is in progress.
REQ-011 err  output  1  sticky error flag.

Function
REQ-012 rx SHALL pass through a 2-flop synchronizer; all receiver decisions use the synchronized value.
REQ-013 Receiver FSM SHALL have states RX_IDLE, RX_START, RX_DATA, RX_STOP.
REQ-014 RX_IDLE -> RX_START on a synchronized high-to-low transition; the bit counter loads CLKS_PER_BIT/2 (integer division).
REQ-015 RX_START SHALL sample at mid-bit: low -> RX_DATA; high -> RX_IDLE (false start, no byte, no error).
REQ-016 RX_DATA SHALL sample 8 bits, each CLKS_PER_BIT cycles after the previous sample, shifting LSB first.
REQ-017 RX_STOP SHALL sample CLKS_PER_BIT cycles after bit 7: high -> one-cycle byte_valid pulse, then RX_IDLE; low -> framing error.
REQ-018 Loader FSM SHALL have states L_LEN, L_DATA, L_DONE, L_ERR; it enters L_LEN on reset.
REQ-019 Byte k (0..3) of each group of four SHALL occupy bits [8k+7:8k] of the assembled word; the byte index wraps 3 -> 0.
REQ-020 L_LEN: on the 4th byte the word SHALL be latched as length N; N == 0 or N > MAX_WORDS -> L_ERR; otherwise -> L_DATA with word_cnt = 0.
REQ-021 L_DATA: on each 4th byte, in the next cycle we = 4'b1111, addr = word_cnt*4, di = the word, for exactly one cycle; word_cnt then increments.
REQ-022 When word_cnt reaches N after a write, the FSM SHALL enter L_DONE; core_rst_n SHALL rise in the cycle after the final we pulse.
REQ-023 L_DONE SHALL be terminal until rst_n: core_rst_n = 1, busy = 0, and further rx traffic is ignored (no we).
REQ-024 A framing error in L_LEN or L_DATA -> L_ERR; L_ERR is terminal until rst_n: err = 1, core_rst_n = 0, busy = 0, no we.
REQ-025 busy SHALL rise on the first accepted start bit (REQ-015 low sample) in L_LEN and fall on entry to L_DONE or L_ERR.
REQ-026 we SHALL be 4'b0000 in every cycle other than those given in REQ-021; addr and di SHALL hold their last values between writes.
REQ-027 word_cnt SHALL be 13 bits wide for the default MAX_WORDS; addr SHALL be {word_cnt, 2'b00} zero-extended to 32 bits.

Reset
REQ-028 While rst_n = 0: we = 0, addr = 0, di = 0, core_rst_n = 0, busy = 0, err = 0; the receiver is in RX_IDLE, the loader is in L_LEN, and all counters are 0.
REQ-029 Asserting rst_n mid-byte or mid-load SHALL abandon all partial state; after release the block SHALL wait for a fresh length header.

Verification (CLKS_PER_BIT = 4)
REQ-030 Send 02 00 00 00, then 13 05 00 00, then 93 05 15 00 -> we pulses at addr 0x0 with di 0x00000513 and at addr 0x4 with di 0x00150593; core_rst_n rises one cycle after the second pulse.
REQ-031 Send a 1-cycle rx low glitch while idle -> no byte_valid, busy stays 0, err stays 0.
REQ-032 Send header 00 00 00 00 -> err = 1, core_rst_n stays 0, no we pulse; a second header is then ignored.
REQ-033 Send header 01 00 00 00, then a data byte with stop bit = 0 -> err = 1, no we, and busy falls.
REQ-034 Pulse rst_n low in the middle of byte 6 of a load -> all outputs return to their reset values; a complete 1-word load afterwards writes addr 0x0 correctly.
REQ-035 Header N = MAX_WORDS + 1 -> err = 1; header N = MAX_WORDS -> the last write occurs at addr (MAX_WORDS-1)*4, then core_rst_n = 1.
